// File: rtl/seq_0101_frame_tx.sv
// seq_0101_frame_tx
// Serial frame transmitter for the 0101 sync-pattern link. Each accepted
// payload is sent MSB first as: SYNC_W sync bits, DATA_W payload bits, and
// one even-parity bit. The line idles at 1, so an overlapping 0101 detector
// downstream sees no false sync between frames. A start seen while the
// parity bit is on the line begins the next frame with no idle gap.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   frame request, taken only while ready=1
//   data   in   payload, captured in the cycle start is taken
//   ready  out  block can accept start this cycle (registered)
//   dout   out  serial line (registered)
//   busy   out  sync, data or parity bit is on dout (registered)
//   done   out  high for the single cycle the parity bit is on dout
module seq_0101_frame_tx #(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b0101
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_PAR  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [DATA_W-1:0]   shreg_r, shreg_s;
  logic                par_r, par_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                dout_r, dout_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                ready_r, ready_s;

  // Even parity bit: 1 when the payload holds an odd number of ones.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Sync bit k of the pattern, counted from the MSB (k = 0 is sent first).
  function automatic logic sync_bit(input logic [CNT_W-1:0] k);
    logic b;
    b = 1'b1;
    for (int i = 0; i < SYNC_W; i++) begin
      if (k == CNT_W'(i)) begin
        b = SYNC[SYNC_W-1-i];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Next-state and next-output logic. cnt_r holds how many bits of the
  // current field are already on the line, including the one showing now.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    par_s   = par_r;
    cnt_s   = cnt_r;
    dout_s  = 1'b1;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      // IDLE and PAR both accept start and share identical next values.
      ST_IDLE, ST_PAR: begin
        if (start) begin
          state_s = ST_SYNC;
          shreg_s = data;
          par_s   = even_parity(data);
          cnt_s   = CNT_W'(1);
          dout_s  = sync_bit(CNT_W'(0));
          busy_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        busy_s = 1'b1;
        if (cnt_r == CNT_W'(SYNC_W)) begin
          state_s = ST_DATA;
          dout_s  = shreg_r[DATA_W-1];
          shreg_s = shreg_r << 1;
          cnt_s   = CNT_W'(1);
        end else begin
          dout_s = sync_bit(cnt_r);
          cnt_s  = cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        busy_s = 1'b1;
        if (cnt_r == CNT_W'(DATA_W)) begin
          state_s = ST_PAR;
          dout_s  = par_r;
          done_s  = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          dout_s  = shreg_r[DATA_W-1];
          shreg_s = shreg_r << 1;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    ready_s = (state_s == ST_IDLE) || (state_s == ST_PAR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      shreg_r <= {DATA_W{1'b0}};
      par_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      dout_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      par_r   <= par_s;
      cnt_r   <= cnt_s;
      dout_r  <= dout_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

  assign dout  = dout_r;
  assign busy  = busy_r;
  assign done  = done_r;
  assign ready = ready_r;

endmodule

// File: tb/tb_seq_0101_frame_tx.sv
// Directed testbench for seq_0101_frame_tx with default parameters.
module tb_seq_0101_frame_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       ready;
  logic       dout;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  seq_0101_frame_tx dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .ready (ready),
    .dout  (dout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Idle line: dout=1, busy=0, done=0, ready=1.
  task automatic chk_idle(input string tag);
    chk({tag, "_dout"},  dout,  1);
    chk({tag, "_busy"},  busy,  0);
    chk({tag, "_done"},  done,  0);
    chk({tag, "_ready"}, ready, 1);
  endtask

  // Called #1 after the accepting edge; checks frame cycles 1..stop_at.
  // exp[12] is the first bit on the line. start is raised during cycle
  // pulse_at and dropped in the next cycle (pulse_at < 0: start untouched).
  task automatic run_frame(input logic [12:0] exp, input int stop_at,
                           input int pulse_at, input string tag);
    for (int c = 1; c <= stop_at; c++) begin
      chk($sformatf("%s_dout_c%0d", tag, c),  dout,  exp[13-c]);
      chk($sformatf("%s_busy_c%0d", tag, c),  busy,  1);
      chk($sformatf("%s_done_c%0d", tag, c),  done,  (c == 13));
      chk($sformatf("%s_ready_c%0d", tag, c), ready, (c == 13));
      if (c == pulse_at) begin
        start = 1'b1;
        data  = 8'h00;
      end else if (c == pulse_at + 1) begin
        start = 1'b0;
      end
      if (c < stop_at) tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;

    // Reset held two cycles, then five idle cycles.
    tick(); chk_idle("rst1");
    tick(); chk_idle("rst2");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk_idle($sformatf("idle%0d", i));
    end

    // Single frame A5: 0101 1010_0101 parity 0.
    start = 1'b1; data = 8'hA5;
    tick(); start = 1'b0;
    run_frame(13'b0101_1010_0101_0, 13, -1, "a5");
    tick(); chk_idle("a5_after");

    // 01: odd number of ones, parity 1.
    start = 1'b1; data = 8'h01;
    tick(); start = 1'b0;
    run_frame(13'b0101_0000_0001_1, 13, -1, "x01");
    tick(); chk_idle("x01_after");

    // 00: parity 0.
    start = 1'b1; data = 8'h00;
    tick(); start = 1'b0;
    run_frame(13'b0101_0000_0000_0, 13, -1, "x00");
    tick(); chk_idle("x00_after");

    // Back-to-back FF then 0F with start held; data change mid-frame ignored.
    start = 1'b1; data = 8'hFF;
    tick(); data = 8'h0F;
    run_frame(13'b0101_1111_1111_0, 13, -1, "bbff");
    tick(); start = 1'b0;
    run_frame(13'b0101_0000_1111_0, 13, -1, "bb0f");
    tick(); chk_idle("bb_after");

    // Start pulsed during cycle 6 is ignored.
    start = 1'b1; data = 8'hA5;
    tick(); start = 1'b0;
    run_frame(13'b0101_1010_0101_0, 13, 6, "ign");
    tick(); chk_idle("ign_after1");
    tick(); chk_idle("ign_after2");

    // Reset during cycle 7 of a 3C frame aborts it; done never pulses.
    start = 1'b1; data = 8'h3C;
    tick(); start = 1'b0;
    run_frame(13'b0101_0011_1100_0, 7, -1, "abrt");
    reset = 1'b1;
    tick(); chk_idle("abrt_rst");
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(); chk_idle($sformatf("abrt_idle%0d", i));
    end

    // Subsequent 3C frame is complete and correct.
    start = 1'b1; data = 8'h3C;
    tick(); start = 1'b0;
    run_frame(13'b0101_0011_1100_0, 13, -1, "x3c");
    tick(); chk_idle("x3c_after");

    // start with reset: reset wins, nothing accepted.
    reset = 1'b1; start = 1'b1; data = 8'h5A;
    tick(); chk_idle("rststart");
    reset = 1'b0; start = 1'b0;
    tick(); chk_idle("rststart_n1");
    tick(); chk_idle("rststart_n2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
